// File: rtl/ie_stage_if.sv
// rtl/ie_stage_if.sv - execute-stage bundle between decode/execute register, hazard unit and memory stage
//
// Purpose: groups every execute-stage input and every execute/memory output
// of ie_stage so the stage is wired as a single bundle.
// Ports (members):
//   E-side control : RegWriteE, JumpE, BranchE, ALUBSrcE, PCTargetALUSrcE,
//                    ALUASrcE, ResultSrcE, MemWriteE, ALUControlE,
//                    LoadSizeE, BranchTypeE
//   E-side data    : RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE
//   hazard/wb      : ForwardAE, ForwardBE, ResultW, StallM
//   redirect       : PCSrcE, PCTargetE
//   M-side outputs : RegWriteM, ResultSrcM, MemWriteM, LoadSizeM, RdM,
//                    ALUResultM, WriteDataM, PCPlus4M
// Modports: master drives the E-side and reads results, slave is the stage.

interface ie_stage_if;
  logic        RegWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUBSrcE;
  logic        PCTargetALUSrcE;
  logic [1:0]  ALUASrcE;
  logic [1:0]  ResultSrcE;
  logic [1:0]  MemWriteE;
  logic [3:0]  ALUControlE;
  logic [2:0]  LoadSizeE;
  logic [2:0]  BranchTypeE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] PCE;
  logic [31:0] ImmExtE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;
  logic        StallM;

  logic        PCSrcE;
  logic [31:0] PCTargetE;

  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [1:0]  MemWriteM;
  logic [2:0]  LoadSizeM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;

  modport master (
    output RegWriteE, JumpE, BranchE, ALUBSrcE, PCTargetALUSrcE,
           ALUASrcE, ResultSrcE, MemWriteE, ALUControlE, LoadSizeE,
           BranchTypeE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE,
           ForwardAE, ForwardBE, ResultW, StallM,
    input  PCSrcE, PCTargetE,
           RegWriteM, ResultSrcM, MemWriteM, LoadSizeM, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, JumpE, BranchE, ALUBSrcE, PCTargetALUSrcE,
           ALUASrcE, ResultSrcE, MemWriteE, ALUControlE, LoadSizeE,
           BranchTypeE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE,
           ForwardAE, ForwardBE, ResultW, StallM,
    output PCSrcE, PCTargetE,
           RegWriteM, ResultSrcM, MemWriteM, LoadSizeM, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/ie_stage.sv
// rtl/ie_stage.sv - pipeline execute stage: forwarding muxes, ALU, branch resolve, EX/MEM register
//
// Purpose: forwards operands, evaluates the ALU, resolves branches/jumps
// combinationally and registers the execute results into the memory stage.
// Ports:
//   clk : sole clock, all state on its rising edge
//   rst : synchronous active-high reset, clears the EX/MEM register
//   bus : ie_stage_if.slave, execute inputs in, redirect and M outputs out

module ie_stage (
  input  logic       clk,
  input  logic       rst,
  ie_stage_if.slave  bus
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  logic [31:0] src_a;
  logic [31:0] write_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [4:0]  shamt;
  logic        lt_signed;
  logic        lt_unsigned;
  logic        equal;
  logic        taken;

  // Forwarding muxes. The memory-stage source is the registered ALUResultM,
  // never this cycle's ALU output, so there is no combinational loop.
  always_comb begin
    src_a = bus.RD1E;
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = bus.ALUResultM;
      default: src_a = bus.RD1E;
    endcase
  end

  always_comb begin
    write_data = bus.RD2E;
    case (bus.ForwardBE)
      2'b01:   write_data = bus.ResultW;
      2'b10:   write_data = bus.ALUResultM;
      default: write_data = bus.RD2E;
    endcase
  end

  // Operand A may be the PC (AUIPC) or zero (LUI via ADD of immediate).
  always_comb begin
    alu_a = 32'h0;
    case (bus.ALUASrcE)
      2'b00:   alu_a = src_a;
      2'b01:   alu_a = bus.PCE;
      default: alu_a = 32'h0;
    endcase
  end

  assign alu_b = bus.ALUBSrcE ? bus.ImmExtE : write_data;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = 32'h0;
    case (bus.ALUControlE)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SLT:  alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'h0, alu_a < alu_b};
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> shamt);
      ALU_PASS: alu_result = alu_b;
      default:  alu_result = 32'h0;
    endcase
  end

  // Branch compare works on the forwarded register values, independent of
  // the ALU operand selects, so the ALU stays free for the target add.
  assign equal       = (src_a == write_data);
  assign lt_signed   = ($signed(src_a) < $signed(write_data));
  assign lt_unsigned = (src_a < write_data);

  always_comb begin
    taken = 1'b0;
    case (bus.BranchTypeE)
      BR_EQ:   taken = equal;
      BR_NE:   taken = ~equal;
      BR_LT:   taken = lt_signed;
      BR_GE:   taken = ~lt_signed;
      BR_LTU:  taken = lt_unsigned;
      BR_GEU:  taken = ~lt_unsigned;
      default: taken = 1'b0;
    endcase
  end

  assign bus.PCSrcE = bus.JumpE | (bus.BranchE & taken);

  // JALR targets come out of the ALU with bit 0 forced low.
  assign bus.PCTargetE = bus.PCTargetALUSrcE ? {alu_result[31:1], 1'b0}
                                             : (bus.PCE + bus.ImmExtE);

  // EX/MEM register: reset beats stall, stall holds every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.RegWriteM  <= 1'b0;
      bus.ResultSrcM <= 2'b00;
      bus.MemWriteM  <= 2'b00;
      bus.LoadSizeM  <= 3'b000;
      bus.RdM        <= 5'd0;
      bus.ALUResultM <= 32'h0;
      bus.WriteDataM <= 32'h0;
      bus.PCPlus4M   <= 32'h0;
    end else if (!bus.StallM) begin
      bus.RegWriteM  <= bus.RegWriteE;
      bus.ResultSrcM <= bus.ResultSrcE;
      bus.MemWriteM  <= bus.MemWriteE;
      bus.LoadSizeM  <= bus.LoadSizeE;
      bus.RdM        <= bus.RdE;
      bus.ALUResultM <= alu_result;
      bus.WriteDataM <= write_data;
      bus.PCPlus4M   <= bus.PCPlus4E;
    end
  end

endmodule

// File: doc/ie_stage.md
IE_STAGE -- requirements
Module: ie_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 RegWriteE, JumpE, BranchE, ALUBSrcE, PCTargetALUSrcE  in  1 each  execute-stage control from the decode/execute register.
REQ-004 ALUASrcE, ResultSrcE, MemWriteE  in  2 each; ALUControlE  in  4; LoadSizeE  in  3; BranchTypeE  in  3 (instr funct3).
REQ-005 RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  32 each; RdE  in  5.
REQ-006 ForwardAE, ForwardBE  in  2 each  operand source select from the hazard unit; ResultW  in  32  writeback result.
REQ-007 StallM  in  1  hold the execute/memory register.
REQ-008 PCSrcE  out  1; PCTargetE  out  32  redirect to fetch.
REQ-009 RegWriteM  out  1; ResultSrcM, MemWriteM  out  2; LoadSizeM  out  3; RdM  out  5.
REQ-010 ALUResultM, WriteDataM, PCPlus4M  out  32  registered execute results.

Function
REQ-011 SrcA mux SHALL select: ForwardAE 00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E.
REQ-012 WriteDataE SHALL select by ForwardBE with the same encoding from RD2E/ResultW/ALUResultM.
REQ-013 ALU operand A SHALL be: ALUASrcE 00 SrcA, 01 PCE, 10/11 zero; operand B SHALL be ImmExtE when ALUBSrcE=1, else WriteDataE.
REQ-014 ALUControlE SHALL decode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 pass B, others zero.
REQ-015 Shift amount SHALL be B[4:0]; SLT/SLTU results SHALL be zero-extended 1-bit; arithmetic wraps modulo 2^32.
REQ-016 Branch compare SHALL use SrcA vs WriteDataE: BranchTypeE 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
REQ-017 PCSrcE SHALL equal JumpE | (BranchE & taken), combinational, same cycle.
REQ-018 PCTargetE SHALL be PCE+ImmExtE when PCTargetALUSrcE=0, else ALU result with bit 0 cleared (JALR).
REQ-019 Execute/memory register SHALL capture RegWriteE, ResultSrcE, MemWriteE, LoadSizeE, RdE, ALU result, WriteDataE, PCPlus4E on every posedge when not stalled; latency exactly 1 cycle.
REQ-020 StallM=1 SHALL hold all registered outputs unchanged; combinational outputs still follow inputs.
REQ-021 ALUResultM forwarding path SHALL use the registered value, never the current-cycle ALU result.
REQ-022 Simultaneous rst and StallM: rst SHALL win.

Reset
REQ-023 On rst=1 at posedge, all registered outputs SHALL become 0 (RegWriteM=0, MemWriteM=00 make the slot a bubble).
REQ-024 Reset mid-stall SHALL clear state; after deassertion capture resumes the next posedge.
REQ-025 PCSrcE and PCTargetE are combinational and not reset; no other state exists.

Verification
REQ-026 ADD: RD1E=5, ImmExtE=7, ALUBSrcE=1, ALUControlE=0000 -> ALUResultM=12 one cycle later.
REQ-027 Forward: ForwardAE=10 with ALUResultM=0x100, RD2E=1, SUB -> next ALUResultM=0xFF.
REQ-028 BLT: BranchE=1, BranchTypeE=100, SrcA=0xFFFFFFFF, WriteDataE=1, PCE=0x40, ImmExtE=8 -> PCSrcE=1, PCTargetE=0x48; BLTU same operands -> PCSrcE=0.
REQ-029 JALR: JumpE=1, PCTargetALUSrcE=1, RD1E=0x1001, ImmExtE=4, ADD -> PCTargetE=0x1004, PCSrcE=1, PCPlus4M=PCPlus4E next cycle.
REQ-030 StallM=1 for 3 cycles with changing inputs -> M outputs frozen; release -> capture on next posedge.
REQ-031 rst asserted during StallM with RegWriteM=1 -> all M outputs 0 after the posedge.
